therm_to_bin_pipe: RTL and testbench
====================================

Name: therm_to_bin_pipe

Overview:
- Pipelined thermometer-to-binary encoder. It is the inverse of the team's 8-to-256 binary-to-thermometer decoder and sits directly downstream of it, for example after a unary DAC-control or comparator-bank path.
- Accepts a 256-bit LSB-aligned thermometer word over a valid/ready handshake and returns the 8-bit binary value plus a code-error flag.
- Has 2-stage elastic buffering with full backpressure support.

Parameters:
- WIDTH, 256: thermometer word width; must be a power of 2 and ≥ 32.
- GROUP_W, 16: bits analysed per group in stage 1; must divide WIDTH.
- OUT_W, $clog2(WIDTH) (=8): binary output width; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  synchronous active-low reset
- din  input  WIDTH  thermometer word; ones packed from bit 0 upward
- din_valid  input  1  din is valid
- din_ready  output  1  block accepts din this cycle
- dout  output  OUT_W  binary value
- dout_err  output  1  din was not a legal thermometer code
- dout_valid  output  1  dout/dout_err are valid
- dout_ready  input  1  downstream accepts dout

Behaviour:
- Legal code: din != 0 and (din & (din+1)) == 0. Value = popcount(din) − 1, so 256'h1 → 0 and all-ones → 255.
  - Equivalently, encoding decoder output din_b gives din_b.
- Reset (resetn low at a clk edge):
  - s1_valid, dout_valid, dout and dout_err all clear to 0.
  - din_ready is 0 while resetn is low.
  - Reset mid-operation discards all in-flight words with no partial output.
- Stage 1 register, one entry per GROUP_W group, each holding:
  - popcount (clog2(GROUP_W)+1 bits)
  - index of highest set bit
  - all_ones flag
  - all_zero flag
  - local_legal flag (nonzero and locally contiguous from bit 0)
- Stage 2 (output) register combines the groups:
  - err=0 iff exactly one boundary group k exists, where all groups below k are all_ones, group k is local_legal, and all groups above k are all_zero.
  - dout = k·GROUP_W + highest-index(k) for a legal word.
- Handshake:
  - s2_load = !dout_valid || dout_ready.
  - din_ready = resetn && (!s1_valid || s2_load).
  - Input transfer on din_valid && din_ready; output transfer on dout_valid && dout_ready.
  - dout, dout_err and dout_valid hold stable while dout_valid && !dout_ready.
- Latency: 2 cycles from accepted input to dout_valid. Throughput is 1 word/cycle when dout_ready is held high.
- Full condition: s1_valid && dout_valid && !dout_ready, which forces din_ready=0. No words are dropped or duplicated and ordering is FIFO.
- Simultaneous events: output consume and s1→s2 advance and new input accept may all occur in one cycle.
- din_valid while din_ready=0: ignored. The upstream stage must hold its data.
- Error words:
  - din=0 → err=1, dout=0.
  - Non-contiguous word → err=1, dout per Optional Feature.
  - Error words are still delivered through the handshake.

Optional Feature:
- Macro: THERM_BUBBLE_CORRECT_EN.
- Defined: dout = popcount(din) − 1 (saturating at 0), giving a bubble-tolerant value.
- Undefined: dout = index of the highest set bit (priority encode).
- In both builds:
  - dout_err is computed identically.
  - Legal codes give identical dout.
  - Latency and handshake are unchanged.

Decomposition:
- Package therm_pkg holds:
  - localparams THERM_W=256, THERM_GROUP_W=16, THERM_NGROUPS=THERM_W/THERM_GROUP_W
  - typedef therm_grp_t, a packed struct {cnt, hi_idx, all_ones, all_zero, local_legal}
- One sub-module therm_group_stat: a combinational GROUP_W-bit analyser producing therm_grp_t, instantiated THERM_NGROUPS times in stage 1.

Test Plan:
- dout_ready=1, din=256'h1 → two cycles later dout=0, dout_err=0, dout_valid=1.
- din = all-ones, then din = 2^100−1 on back-to-back cycles → dout=255, then dout=99, on consecutive cycles with err=0.
- din=0 → dout_err=1, dout=0.
- Bubble word din = (2^100−1) ^ (1<<50) → err=1 in both builds; dout=98 with THERM_BUBBLE_CORRECT_EN defined, dout=99 without.
- Send words encoding 3, 7 and 11 with dout_ready=0 for 6 cycles → din_ready drops after 2 accepts; after release, outputs are 3, 7, 11 in order with no loss.
- Exhaustive sweep of all 256 legal codes (decoder model output) → dout==source value, err=0; then assert resetn=0 mid-stream → dout_valid=0 the next cycle and no stale word appears after release.

Source files
------------

// File: rtl/therm_pkg.sv
// Shared constants and the per-group statistics record for the
// thermometer-to-binary encoder.
package therm_pkg;

   localparam int THERM_W       = 256;
   localparam int THERM_GROUP_W = 16;
   localparam int THERM_NGROUPS = THERM_W / THERM_GROUP_W;
   localparam int THERM_CNT_W   = $clog2(THERM_GROUP_W) + 1;
   localparam int THERM_IDX_W   = $clog2(THERM_GROUP_W);

   typedef struct packed {
      logic [THERM_CNT_W-1:0] cnt;
      logic [THERM_IDX_W-1:0] hi_idx;
      logic                   all_ones;
      logic                   all_zero;
      logic                   local_legal;
   } therm_grp_t;

endpackage

// File: rtl/therm_group_stat.sv
// Combinational analyser for one GROUP_W-bit slice of the thermometer word:
// popcount, highest set bit and the flags stage 2 needs to validate the code.
module therm_group_stat
   import therm_pkg::*;
#(
   parameter int GROUP_W = THERM_GROUP_W
) (
   input  logic [GROUP_W-1:0] grp,
   output therm_grp_t         stat
);

   logic [GROUP_W-1:0] grp_inc_s;

   assign grp_inc_s = grp + GROUP_W'(1);

   // Group statistics; locally contiguous means ones packed from bit 0.
   always_comb begin
      stat             = '0;
      stat.all_ones    = &grp;
      stat.all_zero    = ~|grp;
      stat.local_legal = (grp != '0) && ((grp & grp_inc_s) == '0);
      for (int i = 0; i < GROUP_W; i++) begin
         stat.cnt = stat.cnt + THERM_CNT_W'(grp[i]);
         if (grp[i]) begin
            stat.hi_idx = THERM_IDX_W'(i);
         end else begin
            stat.hi_idx = stat.hi_idx;
         end
      end
   end

endmodule

// File: rtl/therm_to_bin_pipe.sv
// Two-stage elastic thermometer-to-binary encoder with code-error flag.
// Build option THERM_BUBBLE_CORRECT_EN: illegal codes report popcount-1
// instead of the priority-encoded highest set bit.
module therm_to_bin_pipe
   import therm_pkg::*;
#(
   parameter int WIDTH   = THERM_W,
   parameter int GROUP_W = THERM_GROUP_W,
   parameter int OUT_W   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic [OUT_W-1:0] dout,
   output logic             dout_err,
   output logic             dout_valid,
   input  logic             dout_ready
);

   localparam int NGROUPS   = WIDTH / GROUP_W;
   localparam int GRP_IDX_W = $clog2(NGROUPS);

   therm_grp_t grp_stat_s [NGROUPS];
   therm_grp_t s1_stat_r  [NGROUPS];
   logic       s1_valid_r;
   logic       s2_load_s;
   logic       in_xfer_s;

   logic [GRP_IDX_W-1:0] top_grp_s;
   logic                 any_set_s;
   logic                 below_ones_s;
   logic                 legal_s;
   logic [OUT_W-1:0]     val_s;

   for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
      therm_group_stat #(.GROUP_W(GROUP_W)) u_stat (
         .grp  (din[g*GROUP_W +: GROUP_W]),
         .stat (grp_stat_s[g])
      );
   end

   assign s2_load_s = !dout_valid || dout_ready;
   assign din_ready = resetn && (!s1_valid_r || s2_load_s);
   assign in_xfer_s = din_valid && din_ready;

   // Boundary group is the highest non-empty one; everything below must be full.
   always_comb begin
      top_grp_s    = '0;
      any_set_s    = 1'b0;
      below_ones_s = 1'b1;
      for (int g = 0; g < NGROUPS; g++) begin
         if (!s1_stat_r[g].all_zero) begin
            top_grp_s = GRP_IDX_W'(g);
            any_set_s = 1'b1;
         end else begin
            top_grp_s = top_grp_s;
            any_set_s = any_set_s;
         end
      end
      for (int g = 0; g < NGROUPS; g++) begin
         if ((GRP_IDX_W'(g) < top_grp_s) && !s1_stat_r[g].all_ones) begin
            below_ones_s = 1'b0;
         end else begin
            below_ones_s = below_ones_s;
         end
      end
      legal_s = any_set_s && s1_stat_r[top_grp_s].local_legal && below_ones_s;
   end

`ifdef THERM_BUBBLE_CORRECT_EN
   logic [OUT_W:0] total_s;
   logic           idx_unused_s;

   // Whole-word popcount minus one, clamped at zero for an empty word.
   always_comb begin
      total_s      = '0;
      idx_unused_s = 1'b0;
      for (int g = 0; g < NGROUPS; g++) begin
         total_s      = total_s + (OUT_W+1)'(s1_stat_r[g].cnt);
         idx_unused_s = idx_unused_s ^ (^s1_stat_r[g].hi_idx);
      end
      if (total_s == '0) begin
         val_s = '0;
      end else begin
         val_s = OUT_W'(total_s - (OUT_W+1)'(1));
      end
   end
`else
   logic cnt_unused_s;

   // Priority encode: boundary group index concatenated with its top bit.
   always_comb begin
      cnt_unused_s = 1'b0;
      for (int g = 0; g < NGROUPS; g++) begin
         cnt_unused_s = cnt_unused_s ^ (^s1_stat_r[g].cnt);
      end
      val_s = {top_grp_s, s1_stat_r[top_grp_s].hi_idx};
   end
`endif

   // Stage 1: capture group statistics, drain when stage 2 takes the entry.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1_valid_r <= 1'b0;
         for (int g = 0; g < NGROUPS; g++) begin
            s1_stat_r[g] <= '0;
         end
      end else if (in_xfer_s) begin
         s1_valid_r <= 1'b1;
         s1_stat_r  <= grp_stat_s;
      end else if (s2_load_s) begin
         s1_valid_r <= 1'b0;
      end
   end

   // Stage 2: output register, frozen while the consumer stalls.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         dout_valid <= 1'b0;
         dout       <= '0;
         dout_err   <= 1'b0;
      end else if (s2_load_s) begin
         dout_valid <= s1_valid_r;
         if (s1_valid_r) begin
            dout     <= val_s;
            dout_err <= !legal_s;
         end
      end
   end

endmodule

// File: tb/tb_therm_to_bin_pipe.sv
// Self-checking bench for therm_to_bin_pipe: directed cases plus randomized
// traffic scored against a word-level reference model.
module tb_therm_to_bin_pipe;

   localparam int W = 256;

   logic         clk = 1'b0;
   logic         resetn;
   logic [W-1:0] din;
   logic         din_valid;
   logic         din_ready;
   logic [7:0]   dout;
   logic         dout_err;
   logic         dout_valid;
   logic         dout_ready;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_out   = 0;
   bit         last_in = 1'b0;
   logic [7:0] q_val[$];
   logic       q_err[$];

   always #5 clk = ~clk;

   therm_to_bin_pipe dut (
      .clk        (clk),
      .resetn     (resetn),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_err   (dout_err),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] therm(input int v);
      logic [W-1:0] one;
      one = 1;
      return (one << (v + 1)) - one;
   endfunction

   // Reference: legality from whole-word arithmetic, value from popcount or top bit.
   task automatic model(input logic [W-1:0] w, output logic [7:0] val, output logic err);
      int pc;
      int hi;
      pc = $countones(w);
      hi = 0;
      for (int i = 0; i < W; i++) begin
         if (w[i]) hi = i;
      end
      err = !((w != '0) && ((w & (w + 1'b1)) == '0));
`ifdef THERM_BUBBLE_CORRECT_EN
      val = (pc == 0) ? 8'd0 : 8'(pc - 1);
`else
      val = 8'(hi);
`endif
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] w;
      logic [W-1:0] one;
      one = 1;
      case ($urandom_range(0, 3))
         0: w = therm($urandom_range(0, 255));
         1: w = '0;
         2: w = therm($urandom_range(0, 255)) ^ (one << $urandom_range(0, 255));
         default: for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
      endcase
      return w;
   endfunction

   // One clock: score the transfers about to happen, then advance past the edge.
   task automatic tick();
      logic [7:0] mv;
      logic       me;
      #2;
      last_in = 1'b0;
      if (resetn) begin
         if (dout_valid && dout_ready) begin
            n_out++;
            if (q_val.size() == 0) begin
               check("unexpected_out", 32'd1, 32'd0);
            end else begin
               check("sb_dout", dout, q_val.pop_front());
               check("sb_err", dout_err, q_err.pop_front());
            end
         end
         if (din_valid && din_ready) begin
            last_in = 1'b1;
            model(din, mv, me);
            q_val.push_back(mv);
            q_err.push_back(me);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input string tag, input logic [W-1:0] w,
                            input logic [7:0] ev, input logic ee);
      int k;
      dout_ready = 1'b1;
      din        = w;
      din_valid  = 1'b1;
      k = 0;
      do begin
         tick();
         k++;
      end while (!last_in && k < 8);
      din_valid = 1'b0;
      k = 0;
      while (!dout_valid && k < 8) begin
         tick();
         k++;
      end
      check({tag, "_valid"}, dout_valid, 32'd1);
      check({tag, "_dout"}, dout, ev);
      check({tag, "_err"}, dout_err, ee);
      tick();
   endtask

   task automatic drain(input string tag);
      int k;
      din_valid  = 1'b0;
      dout_ready = 1'b1;
      k = 0;
      while (q_val.size() != 0 && k < 20) begin
         tick();
         k++;
      end
      check(tag, q_val.size(), 32'd0);
   endtask

   initial begin
      int         acc;
      int         n0;
      int         k;
      int         idx;
      int         vals[3];
      logic [W-1:0] one;
      logic [7:0] bub_exp;

      one  = 1;
      vals = '{3, 7, 11};

      resetn     = 1'b0;
      din        = '0;
      din_valid  = 1'b1;
      dout_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", dout_valid, 32'd0);
      check("rst_dout", dout, 32'd0);
      check("rst_err", dout_err, 32'd0);
      check("rst_ready", din_ready, 32'd0);
      din_valid = 1'b0;
      resetn    = 1'b1;
      tick();

      // Two-cycle latency on the smallest legal code
      dout_ready = 1'b1;
      din        = therm(0);
      din_valid  = 1'b1;
      tick();
      din_valid = 1'b0;
      check("lat1_valid", dout_valid, 32'd0);
      tick();
      check("lat2_valid", dout_valid, 32'd1);
      check("lat2_dout", dout, 32'd0);
      check("lat2_err", dout_err, 32'd0);
      tick();

      // Back-to-back full scale then 99
      din       = '1;
      din_valid = 1'b1;
      tick();
      din = therm(99);
      tick();
      din_valid = 1'b0;
      check("b2b_first", dout, 32'd255);
      check("b2b_first_valid", dout_valid, 32'd1);
      tick();
      check("b2b_second", dout, 32'd99);
      check("b2b_second_err", dout_err, 32'd0);
      tick();

      send_word("zero", '0, 8'd0, 1'b1);
`ifdef THERM_BUBBLE_CORRECT_EN
      bub_exp = 8'd98;
`else
      bub_exp = 8'd99;
`endif
      send_word("bubble", therm(99) ^ (one << 50), bub_exp, 1'b1);

      // Backpressure: only two words fit while the consumer stalls
      dout_ready = 1'b0;
      idx        = 0;
      acc        = 0;
      din        = therm(vals[0]);
      din_valid  = 1'b1;
      repeat (6) begin
         tick();
         if (last_in) begin
            acc++;
            idx++;
            if (idx < 3) din = therm(vals[idx]);
            else din_valid = 1'b0;
         end
      end
      check("stall_accepts", acc, 32'd2);
      check("stall_ready", din_ready, 32'd0);
      dout_ready = 1'b1;
      n0 = n_out;
      k  = 0;
      while ((n_out - n0) < 3 && k < 20) begin
         tick();
         if (last_in) begin
            acc++;
            din_valid = 1'b0;
         end
         k++;
      end
      check("stall_total_in", acc, 32'd3);
      check("stall_outs", n_out - n0, 32'd3);

      // Randomized traffic with random backpressure; upstream holds unaccepted data
      din_valid = 1'b0;
      last_in   = 1'b0;
      repeat (400) begin
         if (!din_valid || last_in) begin
            din_valid = ($urandom_range(0, 3) != 0);
            din       = rand_word();
         end
         dout_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain("rand_drain");

      // Every legal code, one per cycle
      dout_ready = 1'b1;
      for (int v = 0; v < 256; v++) begin
         din       = therm(v);
         din_valid = 1'b1;
         tick();
         check("sweep_accept", last_in, 32'd1);
      end
      drain("sweep_drain");

      // Reset with both stages occupied
      din       = therm(5);
      din_valid = 1'b1;
      tick();
      din = therm(6);
      tick();
      resetn = 1'b0;
      tick();
      check("midrst_valid", dout_valid, 32'd0);
      check("midrst_ready", din_ready, 32'd0);
      q_val.delete();
      q_err.delete();
      resetn    = 1'b1;
      din_valid = 1'b0;
      n0 = n_out;
      repeat (6) tick();
      check("midrst_no_stale", n_out - n0, 32'd0);
      send_word("post_rst", therm(42), 8'd42, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
